// File: rtl/wired_rf_wport_sched.sv
// wired_rf_wport_sched: round-robin write-port scheduler with init sweep for a 32-entry register file
module wired_rf_wport_sched #(
  parameter int WIDTH = 32,
  parameter int NREQ = 4,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*5-1:0]     req_addr_i,
  input  logic [NREQ*WIDTH-1:0] req_data_i,
  output logic [4:0]            ram_addrw_o,
  output logic [WIDTH-1:0]      ram_din_o,
  output logic                  ram_wea_o,
  output logic                  init_busy_o
);
  localparam int RW = $clog2(NREQ);
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [4:0] cnt;
  logic init_wr;
  logic [NREQ-1:0] buf_v, gnt, acc;
  logic [NREQ-1:0][4:0] buf_addr;
  logic [NREQ-1:0][WIDTH-1:0] buf_data;
  logic [RW-1:0] rr, gi;
  assign init_busy_o = (state == INIT) | init_wr;
  assign req_ready_o = {NREQ{!init_busy_o & !clear_i}} & (~buf_v | gnt);
  assign acc = req_valid_i & req_ready_o;
  always_comb begin
    gnt = '0;
    gi = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (buf_v[RW'((int'(rr) + k) % NREQ)]) begin
        gi = RW'((int'(rr) + k) % NREQ);
        gnt = '0;
        gnt[gi] = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt <= '0;
      init_wr <= 1'b0;
      buf_v <= '0;
      rr <= '0;
      ram_wea_o <= 1'b0;
      ram_addrw_o <= '0;
      ram_din_o <= '0;
    end else if (clear_i) begin
      state <= INIT;
      cnt <= '0;
      init_wr <= 1'b0;
      buf_v <= '0;
      rr <= '0;
      ram_wea_o <= 1'b0;
    end else if (state == INIT) begin
      ram_wea_o <= 1'b1;
      ram_addrw_o <= cnt;
      ram_din_o <= INIT_VAL;
      init_wr <= 1'b1;
      cnt <= cnt + 5'd1;
      state <= (cnt == 5'd31) ? RUN : INIT;
    end else begin
      ram_wea_o <= |gnt;
      init_wr <= 1'b0;
      if (|gnt) begin
        ram_addrw_o <= buf_addr[gi];
        ram_din_o <= buf_data[gi];
        rr <= (gi == RW'(NREQ - 1)) ? '0 : gi + 1'b1;
      end
      buf_v <= (buf_v & ~gnt) | acc;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        buf_addr[i] <= req_addr_i[5*i +: 5];
        buf_data[i] <= req_data_i[WIDTH*i +: WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_wired_rf_wport_sched.sv
// tb_wired_rf_wport_sched: vector table, directed corner cases and a randomized model check
module tb_wired_rf_wport_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic [3:0] valid = '0;
  logic [3:0] ready;
  logic [19:0] addr = '0;
  logic [127:0] data = '0;
  logic [4:0] ram_addrw;
  logic [31:0] ram_din;
  logic ram_wea, init_busy;
  logic [31:0] mem [32];
  int n_tests = 0;
  int n_fail = 0;
  typedef struct {
    logic [3:0] v;
    logic [19:0] a;
    logic [127:0] d;
    logic [3:0] rdy;
    logic w;
    logic [4:0] wa;
    logic [31:0] wd;
  } vec_t;
  vec_t tbl [11];
  localparam logic [19:0] A4 = {5'd4, 5'd3, 5'd2, 5'd1};
  localparam logic [127:0] D4 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [19:0] AS = {5'd0, 5'd5, 5'd0, 5'd0};
  localparam logic [127:0] DS = {32'h0, 32'hDEADBEEF, 64'h0};
  int g, s, maxgap;
  int fcnt [4];
  int flast [4];
  bit allw;
  logic [3:0] er, mv;
  logic [4:0] ma [4];
  logic [31:0] md [4];
  logic [31:0] mm [32];
  int mrr;
  bit ew;
  logic [4:0] ea;
  logic [31:0] ed;
  always #5 clk = ~clk;
  wired_rf_wport_sched #(.WIDTH(32), .NREQ(4), .INIT_VAL(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .clear_i(clear),
    .req_valid_i(valid),
    .req_ready_o(ready),
    .req_addr_i(addr),
    .req_data_i(data),
    .ram_addrw_o(ram_addrw),
    .ram_din_o(ram_din),
    .ram_wea_o(ram_wea),
    .init_busy_o(init_busy)
  );
  always @(posedge clk) if (ram_wea) mem[ram_addrw] <= ram_din;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic sweep(input int last);
    for (int c = 0; c <= last; c++) begin
      #1;
      check("sweep_ctl", {ram_wea, init_busy, ready},
            {(c >= 1 && c <= 32), (c <= 32), (c >= 33) ? 4'hf : 4'h0});
      if (c >= 1 && c <= 32) check("sweep_wr", {ram_addrw, ram_din}, {5'(c - 1), 32'h0});
      tick();
    end
  endtask
  initial begin
    tbl[0]  = '{4'hf, A4, D4, 4'hf, 1'b0, 5'd0, 32'h0};
    tbl[1]  = '{4'h0, 20'h0, 128'h0, 4'h1, 1'b0, 5'd0, 32'h0};
    tbl[2]  = '{4'h0, 20'h0, 128'h0, 4'h3, 1'b1, 5'd1, 32'hA0};
    tbl[3]  = '{4'h0, 20'h0, 128'h0, 4'h7, 1'b1, 5'd2, 32'hA1};
    tbl[4]  = '{4'h0, 20'h0, 128'h0, 4'hf, 1'b1, 5'd3, 32'hA2};
    tbl[5]  = '{4'h0, 20'h0, 128'h0, 4'hf, 1'b1, 5'd4, 32'hA3};
    tbl[6]  = '{4'h0, 20'h0, 128'h0, 4'hf, 1'b0, 5'd0, 32'h0};
    tbl[7]  = '{4'h4, AS, DS, 4'hf, 1'b0, 5'd0, 32'h0};
    tbl[8]  = '{4'h0, 20'h0, 128'h0, 4'hf, 1'b0, 5'd0, 32'h0};
    tbl[9]  = '{4'h0, 20'h0, 128'h0, 4'hf, 1'b1, 5'd5, 32'hDEADBEEF};
    tbl[10] = '{4'h0, 20'h0, 128'h0, 4'hf, 1'b0, 5'd0, 32'h0};
    repeat (3) tick();
    #1;
    check("reset_state", {ram_wea, ram_addrw, ram_din, init_busy, ready}, {1'b0, 5'd0, 32'h0, 1'b1, 4'h0});
    rst = 1'b0;
    sweep(33);
    for (int r = 0; r < 11; r++) begin
      valid = tbl[r].v;
      addr = tbl[r].a;
      data = tbl[r].d;
      #1;
      check("tbl_ready", ready, tbl[r].rdy);
      check("tbl_wea", ram_wea, tbl[r].w);
      if (tbl[r].w) check("tbl_wr", {ram_addrw, ram_din}, {tbl[r].wa, tbl[r].wd});
      tick();
    end
    check("mem1", mem[1], 32'hA0);
    check("mem4", mem[4], 32'hA3);
    check("mem5", mem[5], 32'hDEADBEEF);
    for (int k = 0; k < 19; k++) begin
      valid = (k < 16) ? 4'h2 : 4'h0;
      addr = 20'(k) << 5;
      data = 128'(32'h5000 + k) << 32;
      #1;
      if (k < 16) check("stream_ready", ready[1], 1'b1);
      check("stream_wea", ram_wea, (k >= 2 && k <= 17));
      if (k >= 2 && k <= 17) check("stream_wr", {ram_addrw, ram_din}, {5'(k - 2), 32'h5000 + 32'(k - 2)});
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      fcnt[i] = 0;
      flast[i] = -1;
    end
    maxgap = 0;
    allw = 1'b1;
    for (int t = 0; t <= 48; t++) begin
      valid = (t < 42) ? 4'hf : 4'h0;
      for (int i = 0; i < 4; i++) begin
        addr[5*i +: 5] = 5'($urandom);
        data[32*i +: 32] = {4'(i), 28'(t)};
      end
      #1;
      if (t >= 2 && t <= 41) begin
        if (!ram_wea) allw = 1'b0;
        s = int'(ram_din[31:28]);
        if (ram_wea && s < 4) begin
          fcnt[s]++;
          if (flast[s] >= 0 && t - flast[s] > maxgap) maxgap = t - flast[s];
          flast[s] = t;
        end
      end
      tick();
    end
    check("fair_allwea", allw, 1'b1);
    for (int i = 0; i < 4; i++) check("fair_count", 64'(fcnt[i]), 64'd10);
    check("fair_gap", (maxgap <= 4 && maxgap > 0), 1'b1);
    valid = 4'h7;
    addr = {5'd0, 5'd22, 5'd21, 5'd20};
    data = {32'h0, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
    #1;
    check("clr_pre_ready", ready, 4'hf);
    tick();
    valid = 4'h0;
    clear = 1'b1;
    #1;
    check("clr_ready", ready, 4'h0);
    tick();
    clear = 1'b0;
    sweep(17);
    rst = 1'b1;
    #1;
    check("rst17", {ram_wea, ram_addrw}, {1'b1, 5'd17});
    tick();
    rst = 1'b0;
    sweep(33);
    mv = '0;
    mrr = 0;
    ew = 1'b0;
    for (int e = 0; e < 32; e++) mm[e] = 32'h0;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < 4; i++) begin
        valid[i] = (t < 390) && ($urandom_range(9) < 6);
        addr[5*i +: 5] = 5'($urandom);
        data[32*i +: 32] = $urandom;
      end
      #1;
      g = -1;
      for (int k = 0; k < 4; k++) if (g < 0 && mv[(mrr + k) % 4]) g = (mrr + k) % 4;
      for (int i = 0; i < 4; i++) er[i] = !mv[i] || (g == i);
      check("rnd_ready", ready, er);
      check("rnd_wea", ram_wea, ew);
      if (ew) check("rnd_wr", {ram_addrw, ram_din}, {ea, ed});
      ew = (g >= 0);
      if (g >= 0) begin
        ea = ma[g];
        ed = md[g];
        mm[ea] = ed;
        mv[g] = 1'b0;
        mrr = (g + 1) % 4;
      end
      for (int i = 0; i < 4; i++) begin
        if (valid[i] && er[i]) begin
          mv[i] = 1'b1;
          ma[i] = addr[5*i +: 5];
          md[i] = data[32*i +: 32];
        end
      end
      tick();
    end
    for (int e = 0; e < 32; e++) check("rnd_mem", mem[e], mm[e]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wired_rf_wport_sched.md
Name: wired_rf_wport_sched

Overview:
- Write-port scheduler and initializer for the 32-entry multi-read / single-write LUTRAM register file.
- Arbitrates NREQ writeback sources onto the single write port. Each source has a one-entry holding buffer, and grants rotate round-robin.
- After reset, or on clear, sweeps all 32 entries to INIT_VAL through the same port before accepting writes.
- Sits between the writeback stage and the RAM's addrw/din/wea inputs.

Parameters:
- WIDTH, 32, data width; must match the RAM.
- NREQ, 4, number of writeback requesters; range 2..8.
- INIT_VAL, 0, value written to every entry during the sweep.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- clear_i  in  1  discard buffered writes and restart the init sweep
- req_valid_i  in  NREQ  per-source write request
- req_ready_o  out  NREQ  per-source accept
- req_addr_i  in  NREQ*5  per-source entry address; source i at [5i+4:5i]
- req_data_i  in  NREQ*WIDTH  per-source write data; source i at [WIDTH*i+WIDTH-1:WIDTH*i]
- ram_addrw_o  out  5  to RAM addrw
- ram_din_o  out  WIDTH  to RAM din
- ram_wea_o  out  1  to RAM wea
- init_busy_o  out  1  high while the sweep is not yet committed

Behaviour:
- States: INIT, RUN. A 5-bit sweep counter cnt, per-source buffers buf_v/buf_addr/buf_data, an RR pointer rr of log2(NREQ) bits, and an output register feeding ram_*.
- Reset values:
  - state=INIT, cnt=0, buf_v=0, rr=0
  - ram_wea_o=0, ram_addrw_o=0, ram_din_o=0
  - init_busy_o=1, req_ready_o=0
- Output register: ram_* are always registered. They carry no combinational path from req_*.
- INIT state:
  - Each cycle the output register loads {wea=1, addr=cnt, din=INIT_VAL}, then cnt++.
  - When cnt=31 is loaded, the next state is RUN and cnt returns to 0.
- INIT timing, with C0 the first cycle with rst=0:
  - C0: ram_wea_o=0.
  - C1..C32: ram_wea_o=1 with addr 0..31.
  - The state is RUN from C32.
- init_busy_o = (state==INIT) | (output register holds an init write). It is high through C32 and low from C33.
- req_ready_o[i] = !init_busy_o & (!buf_v[i] | grant[i]). A source can therefore sustain one write per cycle when uncontested.
- Accept: valid&ready in cycle N loads buf[i] at the edge ending N.
- Arbitration, in cycle N+1:
  - The grant goes to the first buf_v set, searching from index rr upward with wrap.
  - The output register loads {1, buf_addr, buf_data}, and buf_v[i] is cleared unless it is reloaded the same cycle.
  - rr becomes (granted index + 1) mod NREQ. If there is no grant, rr holds.
- Latency: accept in N gives ram_wea_o=1 in cycle N+2. The RAM commits at the edge ending N+2.
- Without a grant in RUN, ram_wea_o=0 next cycle. addr and din hold their last value.
- Fairness: with all sources continuously valid, each source gets exactly one grant per NREQ cycles.
- Ordering:
  - Per-source order is preserved.
  - Cross-source writes to the same address in flight together commit in grant order. Upstream guarantees no conflicting same-address writes; the block does not coalesce.
- Read-after-write is the RAM's behaviour. The scheduler provides no bypass.
- clear_i, sampled in any state:
  - Next cycle buf_v=0, state=INIT, cnt=0, rr=0, and ram_wea_o=0.
  - The sweep then restarts exactly as after reset.
  - req_ready_o=0 in the clear cycle itself, so nothing is accepted.
  - An output-register write already loaded before clear_i still commits.
- rst mid-sweep or mid-RUN: all state returns to reset values next cycle, and the sweep restarts from addr 0.
- rst has priority over clear_i.
- Simultaneous accept and grant on the same source: the old entry is granted and the new entry is loaded in the same cycle.

Test Plan:
- Reset release: hold rst for 3 cycles, then drop it. Required: ram_wea_o=0 in C0, then 1 for exactly 32 cycles with addr 0,1,...,31 and din=0. init_busy_o falls in C33, and req_ready_o=4'b1111 from C33.
- Single write: source 2 writes addr=5, data=32'hDEADBEEF in cycle N. Required: ram_wea_o=1, addrw=5, din=DEADBEEF in N+2 only. Readback of entry 5 gives DEADBEEF.
- Contention: all 4 sources become valid in the same cycle with addr 1..4, rr=0. Required: commits in order src0,1,2,3 on consecutive cycles. ready_o is low for the waiting sources until their grant cycle.
- Streaming: source 1 alone issues 16 back-to-back writes to addr 0..15. Required: ready_o[1] stays 1 throughout, and 16 consecutive wea cycles occur in order.
- Fairness: all sources continuously valid for 40 cycles. Required: each source receives 10 grants, with no gap larger than 4 cycles.
- Clear and reset mid-operation:
  - clear_i with 3 buffers full: the buffered writes never reach the RAM, and a fresh 32-write sweep follows.
  - rst at sweep addr 17: the sweep restarts at addr 0.
